datapath_mc: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle processor datapath. It holds the register file, ALU, PC/branch unit and a handshaked data-memory port. It executes one decoded instruction per start/done transaction from the control unit. Memory is external and may insert wait states, so the block sequences each instruction through a state machine instead of completing it in one clock.

---
 rtl/dp_pkg.sv | 44 ++++
 rtl/dp_divider.sv | 65 ++++++
 rtl/datapath_mc.sv | 225 ++++++++++++++++++++++
 tb/tb_datapath_mc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: shared encodings for the multi-cycle datapath.
//   ALU operation codes, branch (pcControl) codes, memop codes,
//   writeback source codes and the sequencing FSM state enum.
package dp_pkg;

  localparam logic [4:0] ALU_PASS = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_MUL  = 5'd3;
  localparam logic [4:0] ALU_DIV  = 5'd4;
  localparam logic [4:0] ALU_REM  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_AND  = 5'd7;
  localparam logic [4:0] ALU_XOR  = 5'd8;
  localparam logic [4:0] ALU_NOT  = 5'd9;
  localparam logic [4:0] ALU_SHR  = 5'd10;
  localparam logic [4:0] ALU_SHL  = 5'd11;

  localparam logic [2:0] PC_INC = 3'd0;
  localparam logic [2:0] PC_EQ  = 3'd1;
  localparam logic [2:0] PC_LT  = 3'd2;
  localparam logic [2:0] PC_GT  = 3'd3;
  localparam logic [2:0] PC_NE  = 3'd4;
  localparam logic [2:0] PC_LE  = 3'd5;
  localparam logic [2:0] PC_GE  = 3'd6;
  localparam logic [2:0] PC_JMP = 3'd7;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam logic [1:0] WC_ALU  = 2'd0;
  localparam logic [1:0] WC_OPB  = 2'd1;
  localparam logic [1:0] WC_LOAD = 2'd2;
  localparam logic [1:0] WC_ONES = 2'd3;

  typedef enum logic [2:0] {IDLE, EXEC, DIV, MEM, WB} state_t;

  // Code 11 is reserved and behaves like "no memory access".
  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == MEM_LOAD) || (op == MEM_STORE);
  endfunction

endpackage

// File: rtl/dp_divider.sv
// dp_divider: iterative restoring divider, one quotient bit per cycle.
//   clock, reset_n      : clock / async active-low reset
//   start_i             : load operands (one-cycle pulse)
//   dividend_i/divisor_i: operands sampled with start_i
//   busy_o              : iterations remaining
//   done_o              : high during the final iteration cycle
//   quotient_o/remainder_o : results, valid while done_o is high
// Divide by zero falls out naturally: every trial subtract succeeds, so the
// quotient is all-ones and the remainder is the dividend.
module dp_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   rem_sh, diff;
  logic              qbit;
  logic [DATA_W-1:0] quo_nx, rem_nx;

  // quo_q starts as the dividend and shifts out its MSB while quotient bits
  // shift in at the bottom.
  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    qbit   = ~diff[DATA_W];
    rem_nx = qbit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quo_nx = {quo_q[DATA_W-2:0], qbit};
  end

  assign busy_o      = (cnt_q != '0);
  assign done_o      = (cnt_q == CNT_W'(1));
  assign quotient_o  = quo_nx;
  assign remainder_o = rem_nx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= CNT_W'(DATA_W);
    end else if (busy_o) begin
      quo_q <= quo_nx;
      rem_q <= rem_nx;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/datapath_mc.sv
// datapath_mc: multi-cycle datapath (register file, ALU, PC/branch unit,
// handshaked data-memory port). One instruction per start/done transaction.
//   state | meaning
//   IDLE  | waiting for start, instruction fields captured on start
//   EXEC  | operands read, ALU result and branch decision latched
//   DIV   | iterative divide in progress (DATAPATH_DIV_EN only)
//   MEM   | mem_req held until mem_ack
//   WB    | done pulse, register writeback, PC update
// Ports: clock/reset_n; start, busy, done handshake; decoded instruction
// fields (alucode, rd, rs, imm, imControl, regenable, memop, pcControl,
// writecode); memory port mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack;
// pc output.
// Build option: define DATAPATH_DIV_EN to build the iterative divider for
// alucode 4/5; otherwise those codes return all-ones.
module datapath_mc
  import dp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter int MADDR_W = 10,
  parameter int PC_W    = 32,
  parameter int OFF_W   = 16,
  localparam int RIDX_W = $clog2(NREGS)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic [4:0]         alucode,
  input  logic [RIDX_W-1:0]  rd,
  input  logic [RIDX_W-1:0]  rs,
  input  logic [DATA_W-1:0]  imm,
  input  logic               imControl,
  input  logic               regenable,
  input  logic [1:0]         memop,
  input  logic [2:0]         pcControl,
  input  logic [1:0]         writecode,
  output logic               mem_req,
  output logic               mem_we,
  output logic [MADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic [PC_W-1:0]    pc
);

  state_t state_q, state_d;

  logic [DATA_W-1:0]  regs_q [NREGS];
  logic [4:0]         alucode_q;
  logic [RIDX_W-1:0]  rd_q, rs_q;
  logic [DATA_W-1:0]  imm_q;
  logic               imctl_q, regen_q;
  logic [1:0]         memop_q, wcode_q;
  logic [2:0]         pcctl_q;
  logic [DATA_W-1:0]  alu_q, opb_q, rdata_q;
  logic               taken_q;
  logic [PC_W-1:0]    pc_q;
  logic               mem_we_q;
  logic [MADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;

  logic [DATA_W-1:0]  op_a, op_b, alu_res, wb_val;
  logic               taken;
  logic [PC_W-1:0]    pc_off;
  logic               is_div;

  always_comb begin
    op_a = (rd_q == '0) ? '0 : regs_q[rd_q];
    op_b = imctl_q ? imm_q : ((rs_q == '0) ? '0 : regs_q[rs_q]);
  end

  // Divide codes are all-ones here: either the divider is not built, or the
  // FSM routes them through DIV and takes the result from the divider.
  always_comb begin
    case (alucode_q)
      ALU_PASS: alu_res = op_a;
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_MUL:  alu_res = op_a * op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOT:  alu_res = ~op_a;
      ALU_SHR:  alu_res = op_a >> 1;
      ALU_SHL:  alu_res = op_a << 1;
      default:  alu_res = '1;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (pcctl_q)
      PC_INC: taken = 1'b0;
      PC_EQ:  taken = (op_a == op_b);
      PC_LT:  taken = (op_a <  op_b);
      PC_GT:  taken = (op_a >  op_b);
      PC_NE:  taken = (op_a != op_b);
      PC_LE:  taken = (op_a <= op_b);
      PC_GE:  taken = (op_a >= op_b);
      PC_JMP: taken = 1'b1;
    endcase
  end

  assign pc_off = {{(PC_W-OFF_W){imm_q[OFF_W-1]}}, imm_q[OFF_W-1:0]};
  assign is_div = (alucode_q == ALU_DIV) || (alucode_q == ALU_REM);

  always_comb begin
    case (wcode_q)
      WC_ALU:  wb_val = alu_q;
      WC_OPB:  wb_val = opb_q;
      WC_LOAD: wb_val = rdata_q;
      default: wb_val = '1;
    endcase
  end

`ifdef DATAPATH_DIV_EN
  logic              div_start, div_busy, div_done;
  logic [DATA_W-1:0] div_quo, div_rem;

  dp_divider #(.DATA_W(DATA_W)) u_div (
    .clock       (clock),
    .reset_n     (reset_n),
    .start_i     (div_start),
    .dividend_i  (op_a),
    .divisor_i   (op_b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign div_start = (state_q == EXEC) && is_div;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = EXEC;
      EXEC: begin
`ifdef DATAPATH_DIV_EN
        if (is_div)                  state_d = DIV;
        else
`endif
        if (is_mem_op(memop_q))      state_d = MEM;
        else                         state_d = WB;
      end
`ifdef DATAPATH_DIV_EN
      DIV:  if (div_done || !div_busy) state_d = is_mem_op(memop_q) ? MEM : WB;
`endif
      MEM:  if (mem_ack) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mem_req decodes straight from the state so an async reset drops it at once.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == WB);
  assign mem_req   = (state_q == MEM);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      alucode_q   <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      imm_q       <= '0;
      imctl_q     <= 1'b0;
      regen_q     <= 1'b0;
      memop_q     <= '0;
      pcctl_q     <= '0;
      wcode_q     <= '0;
      alu_q       <= '0;
      opb_q       <= '0;
      rdata_q     <= '0;
      taken_q     <= 1'b0;
      pc_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          alucode_q <= alucode;
          rd_q      <= rd;
          rs_q      <= rs;
          imm_q     <= imm;
          imctl_q   <= imControl;
          regen_q   <= regenable;
          memop_q   <= memop;
          pcctl_q   <= pcControl;
          wcode_q   <= writecode;
        end
        EXEC: begin
          alu_q   <= alu_res;
          opb_q   <= op_b;
          taken_q <= taken;
          if (is_mem_op(memop_q)) begin
            mem_we_q    <= (memop_q == MEM_STORE);
            mem_addr_q  <= op_b[MADDR_W-1:0];
            mem_wdata_q <= op_a;
          end
        end
`ifdef DATAPATH_DIV_EN
        DIV: if (div_done) alu_q <= (alucode_q == ALU_REM) ? div_rem : div_quo;
`endif
        MEM: if (mem_ack && !mem_we_q) rdata_q <= mem_rdata;
        WB: begin
          pc_q <= taken_q ? pc_q + pc_off : pc_q + PC_W'(1);
          if (regen_q && (rd_q != '0)) regs_q[rd_q] <= wb_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_mc.sv
// Directed testbench for datapath_mc: fixed instruction sequences with
// hand-computed register, PC, memory-port and latency expectations.
module tb_datapath_mc;
  import dp_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy, done;
  logic [4:0]  alucode;
  logic [4:0]  rd, rs;
  logic [31:0] imm;
  logic        imControl, regenable;
  logic [1:0]  memop, writecode;
  logic [2:0]  pcControl;
  logic        mem_req, mem_we, mem_ack;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] pc;

  int n_vec  = 0;
  int n_fail = 0;

  int          r_lat, r_dones, r_req;
  logic [9:0]  r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] mem_model [1024];

  datapath_mc dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .alucode(alucode), .rd(rd), .rs(rs), .imm(imm), .imControl(imControl),
    .regenable(regenable), .memop(memop), .pcControl(pcControl),
    .writecode(writecode), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .pc(pc)
  );

  always #5 clock = ~clock;

  // Issue one instruction from a negedge; acts as the memory (acks after
  // ack_dly extra request cycles) and records latency, done count and port values.
  task automatic run_instr(input logic [4:0] alu, input logic [4:0] rd_v,
                           input logic [4:0] rs_v, input logic [31:0] imm_v,
                           input logic imc, input logic regen,
                           input logic [1:0] mop, input logic [2:0] pcc,
                           input logic [1:0] wc, input int ack_dly, input int hold);
    int cyc, req_cnt;
    bit seen;
    alucode = alu; rd = rd_v; rs = rs_v; imm = imm_v; imControl = imc;
    regenable = regen; memop = mop; pcControl = pcc; writecode = wc;
    start = 1'b1;
    r_lat = -1; r_dones = 0; r_wdata = 'x; r_addr = 'x; r_we = 1'bx;
    cyc = 0; req_cnt = 0; seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      cyc++;
      if (cyc >= hold) start = 1'b0;
      mem_ack = 1'b0;
      if (mem_req) begin
        req_cnt++;
        r_addr = mem_addr; r_we = mem_we; r_wdata = mem_wdata;
        if (req_cnt == ack_dly + 1) begin
          mem_ack = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_model[mem_addr];
        end
      end
      if (done) begin
        r_dones++;
        if (!seen) begin seen = 1; r_lat = cyc; end
      end
      if (seen && cyc >= r_lat + 2) break;
    end
    r_req = req_cnt;
    start = 1'b0;
    mem_ack = 1'b0;
  endtask

  // Register contents are observed through a store: mem_wdata carries regs[rd].
  task automatic read_reg(input logic [4:0] idx);
    run_instr(ALU_PASS, idx, 5'd0, 32'd0, 1'b1, 1'b0, MEM_STORE, PC_INC, WC_ALU, 0, 1);
  endtask

  task automatic test_reset;
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_vec++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    n_vec++; if (mem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_vec++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    n_vec++; if (pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc); end
  endtask

  task automatic test_alu_imm;
    run_instr(ALU_ADD, 5'd3, 5'd0, 32'd5, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_ALU, 0, 1);
    n_vec++; if (r_lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", r_lat); end
    n_vec++; if (r_dones !== 1) begin n_fail++; $display("FAIL add_done_count: got %0d expected 1", r_dones); end
    n_vec++; if (pc !== 32'd1) begin n_fail++; $display("FAIL add_pc: got %h expected 1", pc); end
    read_reg(5'd3);
    n_vec++; if (r_wdata !== 32'd5) begin n_fail++; $display("FAIL r3_value: got %h expected 5", r_wdata); end
  endtask

  task automatic test_r0_and_wrap;
    run_instr(ALU_PASS, 5'd0, 5'd0, 32'hAA, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_OPB, 0, 1);
    read_reg(5'd0);
    n_vec++; if (r_wdata !== 32'd0) begin n_fail++; $display("FAIL r0_reads_zero: got %h expected 0", r_wdata); end
    run_instr(ALU_PASS, 5'd5, 5'd0, 32'd0, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_ONES, 0, 1);
    run_instr(ALU_ADD, 5'd5, 5'd0, 32'd1, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_ALU, 0, 1);
    read_reg(5'd5);
    n_vec++; if (r_wdata !== 32'd0) begin n_fail++; $display("FAIL add_wrap: got %h expected 0", r_wdata); end
    // r6 = 6 - r3 = 1 and r7 = 2 feed the branch test; pc reaches 10 here.
    run_instr(ALU_PASS, 5'd6, 5'd0, 32'd6, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_OPB, 0, 1);
    run_instr(ALU_SUB, 5'd6, 5'd3, 32'd0, 1'b0, 1'b1, MEM_NONE, PC_INC, WC_ALU, 0, 1);
    run_instr(ALU_PASS, 5'd7, 5'd0, 32'd2, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_OPB, 0, 1);
    n_vec++; if (pc !== 32'd10) begin n_fail++; $display("FAIL pc_before_branch: got %h expected a", pc); end
  endtask

  task automatic test_branch;
    run_instr(ALU_PASS, 5'd6, 5'd7, 32'h0000FFFE, 1'b0, 1'b0, MEM_NONE, PC_LT, WC_ALU, 0, 1);
    n_vec++; if (pc !== 32'd8) begin n_fail++; $display("FAIL branch_lt_taken: got %h expected 8", pc); end
    run_instr(ALU_PASS, 5'd6, 5'd0, 32'd3, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_OPB, 0, 1);
    read_reg(5'd6);
    n_vec++; if (r_wdata !== 32'd3) begin n_fail++; $display("FAIL r6_opb_write: got %h expected 3", r_wdata); end
    run_instr(ALU_PASS, 5'd6, 5'd7, 32'h0000FFFE, 1'b0, 1'b0, MEM_NONE, PC_LT, WC_ALU, 0, 1);
    n_vec++; if (pc !== 32'd11) begin n_fail++; $display("FAIL branch_lt_not_taken: got %h expected b", pc); end
    run_instr(ALU_PASS, 5'd3, 5'd3, 32'd4, 1'b0, 1'b0, MEM_NONE, PC_NE, WC_ALU, 0, 1);
    n_vec++; if (pc !== 32'd12) begin n_fail++; $display("FAIL branch_ne_equal: got %h expected c", pc); end
    run_instr(ALU_PASS, 5'd3, 5'd7, 32'd4, 1'b0, 1'b0, MEM_NONE, PC_GE, WC_ALU, 0, 1);
    n_vec++; if (pc !== 32'd16) begin n_fail++; $display("FAIL branch_ge_taken: got %h expected 10", pc); end
  endtask

  task automatic test_mem;
    run_instr(ALU_PASS, 5'd3, 5'd0, 32'd7, 1'b1, 1'b0, MEM_STORE, PC_INC, WC_ALU, 3, 1);
    n_vec++; if (r_req !== 4) begin n_fail++; $display("FAIL store_req_cycles: got %0d expected 4", r_req); end
    n_vec++; if (r_addr !== 10'd7) begin n_fail++; $display("FAIL store_addr: got %h expected 7", r_addr); end
    n_vec++; if (r_we !== 1'b1) begin n_fail++; $display("FAIL store_we: got %b expected 1", r_we); end
    n_vec++; if (r_wdata !== 32'd5) begin n_fail++; $display("FAIL store_wdata: got %h expected 5", r_wdata); end
    n_vec++; if (r_lat !== 6) begin n_fail++; $display("FAIL store_latency: got %0d expected 6", r_lat); end
    run_instr(ALU_PASS, 5'd4, 5'd0, 32'd7, 1'b1, 1'b1, MEM_LOAD, PC_INC, WC_LOAD, 1, 1);
    n_vec++; if (r_we !== 1'b0) begin n_fail++; $display("FAIL load_we: got %b expected 0", r_we); end
    n_vec++; if (r_lat !== 4) begin n_fail++; $display("FAIL load_latency: got %0d expected 4", r_lat); end
    read_reg(5'd4);
    n_vec++; if (r_wdata !== 32'd5) begin n_fail++; $display("FAIL load_r4: got %h expected 5", r_wdata); end
    // pc 19, jump by -10 -> 9
    run_instr(ALU_PASS, 5'd0, 5'd0, 32'h0000FFF6, 1'b1, 1'b0, MEM_NONE, PC_JMP, WC_ALU, 0, 1);
    n_vec++; if (pc !== 32'd9) begin n_fail++; $display("FAIL jump_back: got %h expected 9", pc); end
  endtask

  task automatic test_alu_ops;
    logic [4:0]  ops  [10];
    logic [31:0] imms [10];
    logic [31:0] exps [10];
    ops  = '{ALU_MUL, ALU_XOR, ALU_SHR, ALU_NOT, ALU_SHL, ALU_AND, ALU_OR, ALU_PASS, 5'd13, ALU_SUB};
    imms = '{32'd6, 32'hFF, 32'd0, 32'd0, 32'd0, 32'h0000F0F0, 32'h000F0000, 32'd0, 32'd0, 32'd1};
    exps = '{32'd42, 32'hD5, 32'h6A, 32'hFFFFFF95, 32'hFFFFFF2A, 32'h0000F020, 32'h000FF020,
             32'h000FF020, 32'hFFFFFFFF, 32'hFFFFFFFE};
    run_instr(ALU_PASS, 5'd8, 5'd0, 32'd7, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_OPB, 0, 1);
    for (int i = 0; i < 10; i++) begin
      run_instr(ops[i], 5'd8, 5'd0, imms[i], 1'b1, 1'b1, MEM_NONE, PC_INC, WC_ALU, 0, 1);
      read_reg(5'd8);
      n_vec++;
      if (r_wdata !== exps[i]) begin
        n_fail++; $display("FAIL alu_op_%0d: got %h expected %h", ops[i], r_wdata, exps[i]);
      end
    end
  endtask

  task automatic test_div;
`ifdef DATAPATH_DIV_EN
    logic [31:0] exp_rem0 = 32'd7, exp_q = 32'd14, exp_r = 32'd2;
    int exp_lat = 34;
`else
    logic [31:0] exp_rem0 = 32'hFFFFFFFF, exp_q = 32'hFFFFFFFF, exp_r = 32'hFFFFFFFF;
    int exp_lat = 2;
`endif
    run_instr(ALU_PASS, 5'd9, 5'd0, 32'd7, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_OPB, 0, 1);
    run_instr(ALU_DIV, 5'd9, 5'd0, 32'd0, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_ALU, 0, 1);
    read_reg(5'd9);
    n_vec++; if (r_wdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_by_zero: got %h expected ffffffff", r_wdata); end
    run_instr(ALU_PASS, 5'd9, 5'd0, 32'd7, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_OPB, 0, 1);
    run_instr(ALU_REM, 5'd9, 5'd0, 32'd0, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_ALU, 0, 1);
    read_reg(5'd9);
    n_vec++; if (r_wdata !== exp_rem0) begin n_fail++; $display("FAIL rem_by_zero: got %h expected %h", r_wdata, exp_rem0); end
    run_instr(ALU_PASS, 5'd9, 5'd0, 32'd100, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_OPB, 0, 1);
    run_instr(ALU_DIV, 5'd9, 5'd0, 32'd7, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_ALU, 0, 1);
    n_vec++; if (r_lat !== exp_lat) begin n_fail++; $display("FAIL div_latency: got %0d expected %0d", r_lat, exp_lat); end
    read_reg(5'd9);
    n_vec++; if (r_wdata !== exp_q) begin n_fail++; $display("FAIL div_100_7: got %h expected %h", r_wdata, exp_q); end
    run_instr(ALU_PASS, 5'd9, 5'd0, 32'd100, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_OPB, 0, 1);
    run_instr(ALU_REM, 5'd9, 5'd0, 32'd7, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_ALU, 0, 1);
    read_reg(5'd9);
    n_vec++; if (r_wdata !== exp_r) begin n_fail++; $display("FAIL rem_100_7: got %h expected %h", r_wdata, exp_r); end
  endtask

  task automatic test_back_to_back;
    // start stays high through EXEC and WB; only one transaction may result.
    run_instr(ALU_ADD, 5'd10, 5'd0, 32'd1, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_ALU, 0, 3);
    n_vec++; if (r_dones !== 1) begin n_fail++; $display("FAIL start_while_busy_dones: got %0d expected 1", r_dones); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_while_busy_idle: got %b expected 0", busy); end
    read_reg(5'd10);
    n_vec++; if (r_wdata !== 32'd1) begin n_fail++; $display("FAIL start_while_busy_r10: got %h expected 1", r_wdata); end
  endtask

  task automatic test_reset_mid_mem;
    bit seen = 0;
    alucode = ALU_PASS; rd = 5'd3; rs = 5'd0; imm = 32'd9; imControl = 1'b1;
    regenable = 1'b0; memop = MEM_STORE; pcControl = PC_INC; writecode = WC_ALU;
    mem_ack = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (mem_req) begin seen = 1; break; end
      @(negedge clock);
    end
    n_vec++; if (!seen) begin n_fail++; $display("FAIL abort_req_seen: got 0 expected 1"); end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL abort_mem_req: got %b expected 0", mem_req); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_vec++; if (pc !== 32'd0) begin n_fail++; $display("FAIL abort_pc: got %h expected 0", pc); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_instr(ALU_ADD, 5'd3, 5'd0, 32'd5, 1'b1, 1'b1, MEM_NONE, PC_INC, WC_ALU, 0, 1);
    n_vec++; if (r_lat !== 2) begin n_fail++; $display("FAIL after_abort_latency: got %0d expected 2", r_lat); end
    n_vec++; if (pc !== 32'd1) begin n_fail++; $display("FAIL after_abort_pc: got %h expected 1", pc); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; alucode = '0; rd = '0; rs = '0; imm = '0;
    imControl = 1'b0; regenable = 1'b0; memop = '0; pcControl = '0; writecode = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clock);
    test_reset;
    reset_n = 1'b1;
    @(negedge clock);
    test_alu_imm;
    test_r0_and_wrap;
    test_branch;
    test_mem;
    test_alu_ops;
    test_div;
    test_back_to_back;
    test_reset_mid_mem;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
